adder_stim_ctrl: RTL and testbench
==================================

Name: adder_stim_ctrl

Overview:
- Initiator side of the adder operand/result handshake. It generates pseudo-random operand pairs and issues them on a valid/ready input channel.
- It accepts each sum on a valid/ready output channel, checks the sum against a locally computed A+B, and counts transactions and mismatches.
- It sits opposite the adder wrapper in hardware self-test and FPGA bring-up, replacing the SV testbench driver and monitor.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 1..64.
- CNT_W, 16, width of num_ops, op_count and err_count.
- TIMEOUT_CYCLES, 1024, result wait limit; used only with STIM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE.
- num_ops  in  CNT_W  number of transactions, latched at start.
- seed  in  64  LFSR seed, latched at start; value 0 is replaced by 64'h1.
- op_a  out  WIDTH  operand A.
- op_b  out  WIDTH  operand B.
- op_valid  out  1  operands valid.
- op_ready  in  1  adder accepts operands.
- res_data  in  WIDTH  sum from the adder.
- res_valid  in  1  sum valid.
- res_ready  out  1  controller accepts the sum.
- busy  out  1  high in ISSUE or COLLECT.
- done  out  1  high in DONE.
- op_count  out  CNT_W  completed result handshakes.
- err_count  out  CNT_W  mismatches; saturates at all-ones.
- timeout  out  1  result wait expired (sticky until next start).

Behaviour:
- Reset values: state=IDLE; op_a=op_b=0; op_valid=0; res_ready=0; busy=0; done=0; op_count=0; err_count=0; timeout=0; lfsr=64'h1.
- Transfer rule: a transfer occurs on a rising edge where valid and ready are both 1.
- Transaction limit: one transaction outstanding at a time.
- IDLE/DONE:
  - start=1 latches num_ops and seed, clears both counters and timeout.
  - Goes to ISSUE if num_ops!=0, otherwise DONE.
  - done remains 1 for one cycle through the restart, then reflects the new state.
- ISSUE:
  - On ISSUE entry, op_a and op_b are loaded from two successive LFSR states (low WIDTH bits); op_valid=1.
  - op_a, op_b and op_valid stay stable until the transfer; op_ready low for any number of cycles is tolerated.
  - On transfer: expected=(op_a+op_b) mod 2^WIDTH is registered; op_valid<=0; res_ready<=1; go to COLLECT.
- COLLECT:
  - res_ready=1. On transfer: res_ready<=0 and op_count++.
  - If res_data!=expected, err_count++ (saturating).
  - Then go to ISSUE if op_count+1<num_ops, else DONE.
  - res_valid outside COLLECT is ignored.
- Latency:
  - start edge to op_valid=1: 1 cycle.
  - Operand transfer to res_ready=1: 1 cycle.
  - Result transfer to next op_valid=1: 1 cycle.
- LFSR: 64-bit Fibonacci, taps 64,63,61,60; advances exactly twice per issued pair.
- start while busy is ignored.
- Reset asserted mid-operation returns all outputs asynchronously to their reset values; no partial transaction survives.
- Arithmetic: all sums are modulo 2^WIDTH; no carry-out is checked.

Optional Feature:
- Macro: STIM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in COLLECT and clears on every COLLECT entry.
  - When it reaches TIMEOUT_CYCLES with no result transfer: timeout<=1, err_count++, res_ready<=0, go to DONE (remaining ops abandoned).
- Undefined: no counter is built; timeout is tied to 0; COLLECT waits indefinitely.

Decomposition:
- Package adder_stim_pkg:
  - state enum {IDLE, ISSUE, COLLECT, DONE};
  - LFSR tap constant;
  - SEED_DEFAULT=64'h1.
- Sub-module lfsr64:
  - ports clk, rst, load, seed, step, q;
  - instantiated once.

Test Plan:
- Reset, seed=1, num_ops=1, ideal responder with zero-wait ready -> op_valid 1 cycle after start; done=1, op_count=1, err_count=0.
- num_ops=0, start -> DONE next cycle; op_valid never asserted; op_count=0.
- num_ops=4, responder returns A+B+1 -> err_count=4, op_count=4, done=1.
- num_ops=2, op_ready held low 5 cycles on the first op -> op_a/op_b stable and op_valid=1 throughout; both ops complete with err_count=0.
- WIDTH=8, num_ops=1000, ideal responder -> err_count=0, which confirms mod-256 wrap in expected; reset pulsed mid-COLLECT -> all outputs at reset values immediately.
- STIM_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, responder never asserts res_valid -> timeout=1, err_count=1, done=1 after 16 cycles in COLLECT.

Source files
------------

// File: rtl/adder_stim_pkg.sv
// Shared types and helpers for the adder stimulus controller.
// Holds the controller state encoding, the LFSR tap mask and seed default,
// and the single-step LFSR function used by both the LFSR and the top.
package adder_stim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Taps 64,63,61,60 map to state bits 63,62,60,59.
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED_DEFAULT = 64'h1;

  // One Fibonacci step: shift left, feed the tap parity into bit 0.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  function automatic logic [63:0] seed_fix(input logic [63:0] s);
    return (s == 64'd0) ? SEED_DEFAULT : s;
  endfunction

endpackage

// File: rtl/lfsr64.sv
// 64-bit Fibonacci LFSR for operand generation.
// load selects the (zero-guarded) seed as the base state; step advances the
// base by two states in one cycle, since every operand pair consumes two.
module lfsr64
  import adder_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] q
);

  logic [63:0] base;

  // Pick the state to advance from: a fresh seed on load, else the current state.
  always_comb begin
    base = load ? seed_fix(seed) : q;
  end

  // Hold, reseed, or advance two states per operand pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED_DEFAULT;
    end else if (step) begin
      q <= lfsr_next(lfsr_next(base));
    end else if (load) begin
      q <= base;
    end
  end

endmodule

// File: rtl/adder_stim_ctrl.sv
// Initiator side of the adder operand/result handshake.
// Issues pseudo-random operand pairs, collects each sum, compares it with a
// locally computed A+B and counts transactions and mismatches.
// Optional macro STIM_TIMEOUT_EN adds a result-wait watchdog; without it the
// controller waits for each result indefinitely and timeout stays 0.
module adder_stim_ctrl
  import adder_stim_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic [63:0]      seed,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count,
  output logic             timeout
);

  state_t           state;
  logic [CNT_W-1:0] num_ops_q;
  logic [WIDTH-1:0] expected;
  logic [63:0]      lfsr_q;
  logic [63:0]      pair_src;
  logic [63:0]      pair_next;
  logic [CNT_W:0]   next_count;
  logic             start_ok;
  logic             op_xfer;
  logic             res_xfer;
  logic             last_op;
  logic             issue_next;
  logic             load_pair;
  logic [CNT_W-1:0] err_inc;

  // Handshake qualifiers, next-pair selection and the LFSR control.
  always_comb begin
    start_ok   = start && ((state == IDLE) || (state == DONE));
    op_xfer    = (state == ISSUE) && op_valid && op_ready;
    res_xfer   = (state == COLLECT) && res_ready && res_valid;
    next_count = {1'b0, op_count} + (CNT_W+1)'(1);
    last_op    = next_count >= {1'b0, num_ops_q};
    issue_next = res_xfer && !last_op;
    load_pair  = (start_ok && (num_ops != '0)) || issue_next;
    pair_src   = start_ok ? seed_fix(seed) : lfsr_q;
    pair_next  = lfsr_next(pair_src);
    err_inc    = (&err_count) ? err_count : err_count + CNT_W'(1);
  end

  lfsr64 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .seed (seed),
    .step (load_pair),
    .q    (lfsr_q)
  );

`ifdef STIM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Main controller: start latch, operand issue, result collection and checking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      num_ops_q <= '0;
      expected  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
      res_ready <= 1'b0;
      op_count  <= '0;
      err_count <= '0;
`ifdef STIM_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      if (load_pair) begin
        op_a <= pair_src[WIDTH-1:0];
        op_b <= pair_next[WIDTH-1:0];
      end
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            num_ops_q <= num_ops;
            op_count  <= '0;
            err_count <= '0;
`ifdef STIM_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (num_ops != '0) begin
              op_valid <= 1'b1;
              state    <= ISSUE;
            end else begin
              state    <= DONE;
            end
          end
        end
        ISSUE: begin
          if (op_xfer) begin
            expected  <= op_a + op_b;
            op_valid  <= 1'b0;
            res_ready <= 1'b1;
            state     <= COLLECT;
`ifdef STIM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        COLLECT: begin
          if (res_xfer) begin
            res_ready <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            if (res_data != expected) begin
              err_count <= err_inc;
            end
            if (issue_next) begin
              op_valid <= 1'b1;
              state    <= ISSUE;
            end else begin
              state    <= DONE;
            end
          end
`ifdef STIM_TIMEOUT_EN
          // The watchdog fires on the last of TIMEOUT_CYCLES cycles spent waiting.
          else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            err_count <= err_inc;
            res_ready <= 1'b0;
            state     <= DONE;
          end else begin
            wait_cnt  <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ISSUE) || (state == COLLECT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_adder_stim_ctrl.sv
// Directed bench for adder_stim_ctrl (WIDTH=8).
// A responder on the negative edge plays the adder: it accepts operands,
// returns A+B (optionally corrupted, optionally never), and logs operand pairs.
module tb_adder_stim_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_ops = '0;
  logic [63:0]      seed = '0;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_valid;
  logic             op_ready = 1'b0;
  logic [WIDTH-1:0] res_data = '0;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] op_count, err_count;

  int vectors     = 0;
  int miscompares = 0;

  // Responder state and configuration.
  logic [WIDTH-1:0] inj = '0;
  bit               silent = 0;
  int               stall_left = 0;
  int               stall_seen = 0;
  int               stall_bad = 0;
  bit               snap_valid = 0;
  logic [WIDTH-1:0] snap_a = '0, snap_b = '0;
  bit               have_result = 0;
  bit               fire_op = 0, fire_res = 0;
  logic [WIDTH-1:0] cap_a = '0, cap_b = '0, pend_sum = '0;
  int               op_seen = 0;
  logic [WIDTH-1:0] log_a [0:7];
  logic [WIDTH-1:0] log_b [0:7];

  adder_stim_ctrl #(
    .WIDTH          (WIDTH),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .seed      (seed),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .op_count  (op_count),
    .err_count (err_count),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Adder model: decide ready/valid on the falling edge, so the decision holds at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      op_ready    = 1'b0;
      res_valid   = 1'b0;
      res_data    = '0;
      have_result = 0;
      fire_op     = 0;
      fire_res    = 0;
    end else begin
      if (fire_res) res_valid = 1'b0;
      if (fire_op) begin
        have_result = 1;
        pend_sum    = cap_a + cap_b + inj;
      end
      fire_op  = 0;
      fire_res = 0;
      op_ready = 1'b0;
      if (op_valid && !have_result) begin
        if (stall_left > 0) begin
          if (!snap_valid) begin
            snap_a     = op_a;
            snap_b     = op_b;
            snap_valid = 1;
          end else if (op_a !== snap_a || op_b !== snap_b) begin
            stall_bad++;
          end
          stall_seen++;
          stall_left--;
        end else begin
          op_ready = 1'b1;
        end
      end
      if (have_result && !silent) begin
        res_valid = 1'b1;
        res_data  = pend_sum;
      end
      if (op_valid && op_ready) begin
        fire_op = 1;
        cap_a   = op_a;
        cap_b   = op_b;
        if (op_seen < 8) begin
          log_a[op_seen] = op_a;
          log_b[op_seen] = op_b;
        end
        op_seen++;
      end
      if (res_valid && res_ready) begin
        fire_res    = 1;
        have_result = 0;
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [63:0] s, input logic [WIDTH-1:0] e,
                               input int st, input bit sil);
    @(negedge clk);
    inj        = e;
    silent     = sil;
    stall_left = st;
    stall_seen = 0;
    stall_bad  = 0;
    snap_valid = 0;
    op_seen    = 0;
    num_ops    = CNT_W'(n);
    seed       = s;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, done, 1);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_op_a"}, op_a, 0);
    checkOutput({tag, "_op_b"}, op_b, 0);
    checkOutput({tag, "_op_valid"}, op_valid, 0);
    checkOutput({tag, "_res_ready"}, res_ready, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_op_count"}, op_count, 0);
    checkOutput({tag, "_err_count"}, err_count, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    // Reset state.
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst = 1'b1;

    // One op, seed 1: pair (1,2), one cycle start-to-valid.
    applyStimulus(1, 64'h1, 8'd0, 0, 0);
    checkOutput("t1_valid_lat", op_valid, 1);
    checkOutput("t1_busy", busy, 1);
    wait_done("t1", 50);
    checkOutput("t1_op_count", op_count, 1);
    checkOutput("t1_err", err_count, 0);
    checkOutput("t1_a0", log_a[0], 8'h01);
    checkOutput("t1_b0", log_b[0], 8'h02);

    // Zero ops: straight to DONE, no operand ever offered.
    applyStimulus(0, 64'h1, 8'd0, 0, 0);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_busy", busy, 0);
    repeat (4) @(negedge clk);
    checkOutput("t2_valid", op_valid, 0);
    checkOutput("t2_seen", op_seen, 0);
    checkOutput("t2_op_count", op_count, 0);

    // Four ops with every sum off by one; seed 1 walks single bits.
    applyStimulus(4, 64'h1, 8'd1, 0, 0);
    wait_done("t3", 100);
    checkOutput("t3_err", err_count, 4);
    checkOutput("t3_op_count", op_count, 4);
    checkOutput("t3_timeout", timeout, 0);
    checkOutput("t3_a1", log_a[1], 8'h04);
    checkOutput("t3_b1", log_b[1], 8'h08);
    checkOutput("t3_a3", log_a[3], 8'h40);
    checkOutput("t3_b3", log_b[3], 8'h80);

    // Two ops, first held off for 5 cycles; seed bit 63 exercises the feedback.
    applyStimulus(2, 64'h8000_0000_0000_0003, 8'd0, 5, 0);
    wait_done("t4", 100);
    checkOutput("t4_stall_seen", stall_seen, 5);
    checkOutput("t4_stall_stable", stall_bad, 0);
    checkOutput("t4_snap_a", snap_a, 8'h03);
    checkOutput("t4_a0", log_a[0], 8'h03);
    checkOutput("t4_b0", log_b[0], 8'h07);
    checkOutput("t4_a1", log_a[1], 8'h0E);
    checkOutput("t4_b1", log_b[1], 8'h1C);
    checkOutput("t4_op_count", op_count, 2);
    checkOutput("t4_err", err_count, 0);

    // Zero seed is replaced by 1.
    applyStimulus(1, 64'h0, 8'd0, 0, 0);
    wait_done("t5", 50);
    checkOutput("t5_a0", log_a[0], 8'h01);
    checkOutput("t5_b0", log_b[0], 8'h02);

    // A start pulse while busy must not restart the run.
    applyStimulus(3, 64'h1, 8'd0, 0, 0);
    begin
      int n = 0;
      while (op_seen < 1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    num_ops = 16'd1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done("t6", 100);
    checkOutput("t6_op_count", op_count, 3);
    checkOutput("t6_seen", op_seen, 3);

    // Long run; 8-bit sums wrap, the controller must still see no errors.
    applyStimulus(1000, 64'h1234_5678_9ABC_DEF0, 8'd0, 0, 0);
    wait_done("t7", 20000);
    checkOutput("t7_op_count", op_count, 1000);
    checkOutput("t7_err", err_count, 0);
    checkOutput("t7_seen", op_seen, 1000);

    // Reset dropped while waiting in COLLECT clears everything without a clock edge.
    applyStimulus(5, 64'h1, 8'd0, 0, 1);
    begin
      int n = 0;
      while (!res_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("t8_collect", res_ready, 1);
    #2 rst = 1'b0;
    #1;
    check_reset_values("t8");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

`ifdef STIM_TIMEOUT_EN
    // No result ever: watchdog ends the run after TO cycles in COLLECT.
    applyStimulus(2, 64'h1, 8'd0, 0, 1);
    begin
      int n = 0;
      while (!res_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      checkOutput("t9_cycles", n, TO);
    end
    checkOutput("t9_done", done, 1);
    checkOutput("t9_timeout", timeout, 1);
    checkOutput("t9_err", err_count, 1);
    checkOutput("t9_op_count", op_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
